seq_alu_unit: RTL and testbench

- Parametrised multi-cycle successor to the datapath's combinational ALU.
- Executes AND/OR/ADD/SUB/SLT/SRL in one registered cycle.
- Executes unsigned multiply (MULTU) as a WIDTH-cycle shift-add into internal HI/LO registers, read back with MFHI/MFLO.
- Sits in the EX stage; the control unit drives `start`/`Signal` and stalls on `busy`.

---
 rtl/seq_alu_unit_if.sv | 23 ++
 rtl/seq_alu_unit.sv | 135 +++++++++++++
 tb/tb_seq_alu_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_unit_if.sv
// rtl/seq_alu_unit_if.sv - request/result bundle between the EX-stage control and seq_alu_unit
interface seq_alu_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataOut;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, dataA, dataB, Signal,
        input  dataOut, overflow, busy, done
    );

    modport slave (
        input  start, dataA, dataB, Signal,
        output dataOut, overflow, busy, done
    );
endinterface

// File: rtl/seq_alu_unit.sv
// rtl/seq_alu_unit.sv - multi-cycle ALU: single-cycle logic/arith/shift ops plus shift-add MULTU into HI/LO
module seq_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    seq_alu_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] hi_nx, lo_nx;

    always_comb begin
        sum     = bus.dataA + bus.dataB;
        diff    = bus.dataA + ~bus.dataB + WIDTH'(1);
        add_ovf = (bus.dataA[WIDTH-1] == bus.dataB[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.dataA[WIDTH-1]);
        sub_ovf = (bus.dataA[WIDTH-1] != bus.dataB[WIDTH-1]) &&
                  (diff[WIDTH-1] != bus.dataA[WIDTH-1]);
        // One shift-add step: carry out of HI+M becomes the new HI msb, HI lsb shifts into LO
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        hi_nx   = mul_sum[WIDTH:1];
        lo_nx   = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = DONE;
                    ovf_d   = 1'b0;
                    case (bus.Signal)
                        OP_AND:  dout_d = bus.dataA & bus.dataB;
                        OP_OR:   dout_d = bus.dataA | bus.dataB;
                        OP_ADD: begin
                            dout_d = sum;
                            ovf_d  = add_ovf;
                        end
                        OP_SUB: begin
                            dout_d = diff;
                            ovf_d  = sub_ovf;
                        end
                        OP_SLT:  dout_d = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
                        OP_SRL:  dout_d = bus.dataA >> bus.dataB[SHW-1:0];
                        OP_MFHI: dout_d = hi_q;
                        OP_MFLO: dout_d = lo_q;
                        OP_MULTU: begin
                            state_d = MUL;
                            m_d     = bus.dataA;
                            hi_d    = '0;
                            lo_d    = bus.dataB;
                            cnt_d   = CW'(WIDTH);
                            dout_d  = dout_q;
                            ovf_d   = ovf_q;
                        end
                        default: dout_d = '0;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                hi_d  = hi_nx;
                lo_d  = lo_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    dout_d  = lo_nx;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.dataOut  = dout_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q == MUL);
    assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_seq_alu_unit.sv
// tb/tb_seq_alu_unit.sv - scoreboard bench for seq_alu_unit at WIDTH=32
module tb_seq_alu_unit;
    localparam int W = 32;

    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;

    typedef struct packed {
        logic [31:0] d;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_alu_unit_if #(.WIDTH(W)) bus ();
    seq_alu_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t        sb[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] hi_m    = '0;
    logic [31:0] lo_m    = '0;

    function automatic exp_t model(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] t;
        e = '0;
        case (s)
            OP_AND: e.d = a & b;
            OP_OR:  e.d = a | b;
            OP_ADD: begin
                t   = {a[31], a} + {b[31], b};
                e.d = t[31:0];
                e.o = t[32] ^ t[31];
            end
            OP_SUB: begin
                t   = {a[31], a} - {b[31], b};
                e.d = t[31:0];
                e.o = t[32] ^ t[31];
            end
            OP_SLT:  e.d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SRL:  e.d = a >> b[4:0];
            OP_MFHI: e.d = hi_m;
            OP_MFLO: e.d = lo_m;
            default: e.d = '0;
        endcase
        return e;
    endfunction

    // One single-cycle op from IDLE: done one cycle, result matches the model
    task automatic do_op(input string name, input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        sb.push_back(model(s, a, b));
        bus.start  = 1'b1;
        bus.Signal = s;
        bus.dataA  = a;
        bus.dataB  = b;
        @(negedge clk);
        bus.start = 1'b0;
        e = sb.pop_front();
        n_total++;
        if (bus.done !== 1'b1) $display("FAIL %s done got %b exp 1", name, bus.done);
        else n_pass++;
        n_total++;
        if (bus.dataOut !== e.d) $display("FAIL %s dataOut got %h exp %h", name, bus.dataOut, e.d);
        else n_pass++;
        n_total++;
        if (bus.overflow !== e.o) $display("FAIL %s overflow got %b exp %b", name, bus.overflow, e.o);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.done !== 1'b0) $display("FAIL %s done_drop got %b exp 0", name, bus.done);
        else n_pass++;
    endtask

    task automatic run_multu(input string name, input logic [31:0] a, input logic [31:0] b, input int pulse_at);
        logic [63:0] p;
        exp_t        e;
        int          busy_cyc, dones, done_at;
        bit          clash;
        p = {32'b0, a} * {32'b0, b};
        e.d = p[31:0];
        e.o = 1'b0;
        sb.push_back(e);
        busy_cyc = 0; dones = 0; done_at = -1; clash = 0;
        bus.start  = 1'b1;
        bus.Signal = OP_MULTU;
        bus.dataA  = a;
        bus.dataB  = b;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            if (bus.busy) busy_cyc++;
            if (bus.busy && bus.done) clash = 1;
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    done_at = i;
                    e = sb.pop_front();
                    n_total++;
                    if (bus.dataOut !== e.d) $display("FAIL %s dataOut got %h exp %h", name, bus.dataOut, e.d);
                    else n_pass++;
                    n_total++;
                    if (bus.overflow !== e.o) $display("FAIL %s overflow got %b exp %b", name, bus.overflow, e.o);
                    else n_pass++;
                end
            end
            if (i == pulse_at) begin
                bus.start  = 1'b1;
                bus.Signal = OP_ADD;
                bus.dataA  = 32'd9;
                bus.dataB  = 32'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        if (dones == 0) sb.delete();
        n_total++;
        if (busy_cyc != W) $display("FAIL %s busy_cycles got %0d exp %0d", name, busy_cyc, W);
        else n_pass++;
        n_total++;
        if (dones != 1) $display("FAIL %s done_pulses got %0d exp 1", name, dones);
        else n_pass++;
        n_total++;
        if (done_at != W) $display("FAIL %s done_latency got %0d exp %0d", name, done_at, W);
        else n_pass++;
        n_total++;
        if (clash) $display("FAIL %s busy_and_done got 1 exp 0", name);
        else n_pass++;
        hi_m = p[63:32];
        lo_m = p[31:0];
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.Signal = '0;
        bus.dataA  = '0;
        bus.dataB  = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if (bus.dataOut !== 32'd0) $display("FAIL reset dataOut got %h exp 0", bus.dataOut);
        else n_pass++;
        n_total++;
        if (bus.overflow !== 1'b0) $display("FAIL reset overflow got %b exp 0", bus.overflow);
        else n_pass++;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL reset busy got %b exp 0", bus.busy);
        else n_pass++;
        n_total++;
        if (bus.done !== 1'b0) $display("FAIL reset done got %b exp 0", bus.done);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        do_op("reset_mfhi", OP_MFHI, 32'd0, 32'd0);
        do_op("reset_mflo", OP_MFLO, 32'd0, 32'd0);
    endtask

    task automatic test_arith();
        do_op("add_7_5",     OP_ADD, 32'd7,         32'd5);
        do_op("sub_5_7",     OP_SUB, 32'd5,         32'd7);
        do_op("add_ovf",     OP_ADD, 32'h7FFFFFFF,  32'd1);
        do_op("sub_ovf",     OP_SUB, 32'h80000000,  32'd1);
        do_op("slt_neg1_1",  OP_SLT, 32'hFFFFFFFF,  32'd1);
        do_op("slt_min_max", OP_SLT, 32'h80000000,  32'h7FFFFFFF);
        do_op("slt_false",   OP_SLT, 32'd1,         32'hFFFFFFFF);
        do_op("srl_31",      OP_SRL, 32'h80000000,  32'd31);
        do_op("srl_hibits",  OP_SRL, 32'hF0000000,  32'hFFFFFFE4);
        do_op("or",          OP_OR,  32'hA5A50000,  32'h00005A5A);
    endtask

    task automatic test_multu();
        run_multu("multu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        do_op("mfhi_max", OP_MFHI, 32'd0, 32'd0);
        do_op("mflo_max", OP_MFLO, 32'd0, 32'd0);
        do_op("and",      OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0);
        do_op("mfhi_kept", OP_MFHI, 32'd0, 32'd0);
    endtask

    task automatic test_random();
        logic [5:0] ops[9];
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL, OP_MFHI, OP_MFLO, 6'b111111};
        for (int i = 0; i < 20; i++)
            do_op("random", ops[$urandom_range(0, 8)], $urandom, $urandom);
    endtask

    task automatic test_multu_ignore();
        run_multu("multu_3x5", 32'd3, 32'd5, 5);
        do_op("mfhi_3x5", OP_MFHI, 32'd0, 32'd0);
        do_op("mflo_3x5", OP_MFLO, 32'd0, 32'd0);
    endtask

    task automatic test_reset_mid_mul();
        int dones;
        bus.start  = 1'b1;
        bus.Signal = OP_MULTU;
        bus.dataA  = 32'h00001234;
        bus.dataB  = 32'h00005678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL rst_mid busy got %b exp 0", bus.busy);
        else n_pass++;
        n_total++;
        if (bus.done !== 1'b0) $display("FAIL rst_mid done got %b exp 0", bus.done);
        else n_pass++;
        n_total++;
        if (bus.dataOut !== 32'd0) $display("FAIL rst_mid dataOut got %h exp 0", bus.dataOut);
        else n_pass++;
        hi_m = '0;
        lo_m = '0;
        dones = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_total++;
        if (dones != 0) $display("FAIL rst_mid late_done got %0d exp 0", dones);
        else n_pass++;
        do_op("rst_mid_mflo", OP_MFLO, 32'd0, 32'd0);
        do_op("rst_mid_mfhi", OP_MFHI, 32'd0, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [5:0]  sigs[4];
        logic [31:0] av[4];
        exp_t        e;
        sigs = '{OP_ADD, OP_ADD, OP_ADD, 6'b111111};
        av   = '{32'd1, 32'd2, 32'd3, 32'd77};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(model(sigs[i], av[i], av[i]));
            bus.start  = 1'b1;
            bus.Signal = sigs[i];
            bus.dataA  = av[i];
            bus.dataB  = av[i];
            @(negedge clk);
            e = sb.pop_front();
            n_total++;
            if (bus.done !== 1'b1) $display("FAIL b2b[%0d] done got %b exp 1", i, bus.done);
            else n_pass++;
            n_total++;
            if (bus.dataOut !== e.d) $display("FAIL b2b[%0d] dataOut got %h exp %h", i, bus.dataOut, e.d);
            else n_pass++;
        end
        bus.start = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.done !== 1'b0) $display("FAIL b2b_end done got %b exp 0", bus.done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_multu();
        test_random();
        test_multu_ignore();
        test_reset_mid_mul();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
